cpu_run_ctrl: RTL

// Run-control scheduler for the RISC-V core clocking. Replaces free-running divided clocks with

---
 rtl/cpu_run_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run-control scheduler for the core: turns board buttons and the core halt request into
// single-cycle clock-enable pulses at a selectable rate on the main clock.
module cpu_run_ctrl #(
    parameter int unsigned DIV_W = 32,
    parameter int unsigned DIV0  = 10,
    parameter int unsigned DIV1  = 1000,
    parameter int unsigned DIV2  = 100000,
    parameter int unsigned DIV3  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        halt_btn,
    input  logic        cpu_halt_req,
    input  logic [1:0]  speed_sel,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic        running,
    output logic [31:0] ce_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Divisors are truncated to DIV_W bits; a zero divisor behaves as one.
    localparam logic [DIV_W-1:0] D0_T = DIV_W'(DIV0);
    localparam logic [DIV_W-1:0] D1_T = DIV_W'(DIV1);
    localparam logic [DIV_W-1:0] D2_T = DIV_W'(DIV2);
    localparam logic [DIV_W-1:0] D3_T = DIV_W'(DIV3);
    localparam logic [DIV_W-1:0] D0   = (D0_T == '0) ? DIV_W'(1) : D0_T;
    localparam logic [DIV_W-1:0] D1   = (D1_T == '0) ? DIV_W'(1) : D1_T;
    localparam logic [DIV_W-1:0] D2   = (D2_T == '0) ? DIV_W'(1) : D2_T;
    localparam logic [DIV_W-1:0] D3   = (D3_T == '0) ? DIV_W'(1) : D3_T;

    state_t           state_q, state_n;
    logic             ce_q, ce_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [DIV_W-1:0] div_sel;
    logic [31:0]      ce_count_q;

    // Bit order for the button chains: {halt, step, run}.
    logic [2:0] btn_s1, btn_s2, btn_s3;
    logic [2:0] btn_edge;
    logic       run_e, step_e, halt_e;

    assign btn_edge = btn_s2 & ~btn_s3;
    assign run_e    = btn_edge[0];
    assign step_e   = btn_edge[1];
    assign halt_e   = btn_edge[2];

    always_comb begin
        div_sel = D0;
        case (speed_sel)
            2'd0: div_sel = D0;
            2'd1: div_sel = D1;
            2'd2: div_sel = D2;
            2'd3: div_sel = D3;
            default: div_sel = D0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1     <= '0;
            btn_s2     <= '0;
            btn_s3     <= '0;
            state_q    <= ST_HALT;
            ce_q       <= 1'b0;
            cnt_q      <= '0;
            div_q      <= D0;
            ce_count_q <= '0;
        end else begin
            btn_s1     <= {halt_btn, step_btn, run_btn};
            btn_s2     <= btn_s1;
            btn_s3     <= btn_s2;
            state_q    <= state_n;
            ce_q       <= ce_n;
            cnt_q      <= cnt_n;
            div_q      <= div_n;
            if (ce_q) begin
                ce_count_q <= ce_count_q + 32'd1;
            end
        end
    end

    // Priority on coincident events: halt request, halt edge, step edge, run edge.
    always_comb begin
        state_n = state_q;
        ce_n    = 1'b0;
        cnt_n   = cnt_q;
        div_n   = div_q;
        case (state_q)
            ST_HALT: begin
                if (cpu_halt_req) begin
                    state_n = ST_DONE;
                end else if (halt_e) begin
                    state_n = ST_HALT;
                end else if (step_e) begin
                    state_n = ST_STEP;
                    ce_n    = 1'b1;
                end else if (run_e) begin
                    state_n = ST_RUN;
                    cnt_n   = '0;
                    div_n   = div_sel;
                end
            end
            ST_RUN: begin
                if (cpu_halt_req) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end else if (halt_e) begin
                    state_n = ST_HALT;
                    cnt_n   = '0;
                end else if (cnt_q == div_q - DIV_W'(1)) begin
                    cnt_n = '0;
                    ce_n  = 1'b1;
                    div_n = div_sel;
                end else begin
                    cnt_n = cnt_q + DIV_W'(1);
                end
            end
            ST_STEP: begin
                state_n = cpu_halt_req ? ST_DONE : ST_HALT;
            end
            ST_DONE: begin
                state_n = ST_DONE;
            end
            default: begin
                state_n = ST_HALT;
            end
        endcase
    end

    assign cpu_ce   = ce_q;
    assign state    = state_q;
    assign running  = (state_q == ST_RUN);
    assign ce_count = ce_count_q;

endmodule
